// File: rtl/if_fetch_queue_if.sv
// Decode-side handshake bundle for if_fetch_queue.
// master: fetch queue (drives the head pair and valid); slave: decode stage.
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32
);
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] inst_to_decode;
  logic [ADDR_W-1:0] pc_to_ID;

  modport master (
    output id_valid,
    output inst_to_decode,
    output pc_to_ID,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  inst_to_decode,
    input  pc_to_ID,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage between the PC register and decode.
// Issues pc to the ROM, captures the word one cycle later into a small FIFO of
// {pc, inst} pairs, and hands pairs to decode over valid/ready. stall is raised
// when queued entries plus the in-flight fetch fill the buffer; branch flushes
// the queue and drops the in-flight response.
// Optional build macro IF_BYPASS_EN: when the queue is empty, a fresh ROM
// response is presented to decode in the same cycle it arrives.
module if_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch,
  output logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_to_ROM,
  input  logic [ADDR_W-1:0] inst_from_ROM,
  if_fetch_queue_if.master  id_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] FULL_SUM = (CNT_W + 1)'(DEPTH);

  // Queue storage, split into pc and instruction halves
  logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
  logic [ADDR_W-1:0] mem_inst_r [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] inflight_pc_r;

  logic [CNT_W:0]    credit_sum_s;
  logic              queue_valid_s;
  logic              resp_s;
  logic              bypass_s;
  logic              push_s;
  logic              pop_s;
  logic              head_valid_s;
  logic [ADDR_W-1:0] head_inst_s;
  logic [ADDR_W-1:0] head_pc_s;

  // Credit check from registered state and ROM issue strobe
  always_comb begin
    credit_sum_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    stall        = (credit_sum_s >= FULL_SUM);
    rd_en        = start & ~stall & ~branch & ~reset;
    addr_to_ROM  = pc;
  end

  // Head selection, push/pop qualification
  always_comb begin
    queue_valid_s = (count_r != {CNT_W{1'b0}});
    // A response arriving in a flush cycle is discarded
    resp_s        = inflight_r & ~branch;
`ifdef IF_BYPASS_EN
    bypass_s      = resp_s & ~queue_valid_s;
`else
    bypass_s      = 1'b0;
`endif
    head_valid_s  = queue_valid_s;
    head_inst_s   = mem_inst_r[rd_ptr_r];
    head_pc_s     = mem_pc_r[rd_ptr_r];
    if (bypass_s) begin
      head_valid_s = 1'b1;
      head_inst_s  = inst_from_ROM;
      head_pc_s    = inflight_pc_r;
    end else begin
      head_valid_s = queue_valid_s;
    end
    // A bypassed response taken by decode never enters the queue
    push_s = resp_s & ~(bypass_s & id_if.id_ready);
    // A handshake during flush is accepted but does not move the read pointer
    pop_s  = queue_valid_s & id_if.id_ready & ~branch;
  end

  // Drive the decode-side bundle
  always_comb begin
    id_if.id_valid       = head_valid_s;
    id_if.inst_to_decode = head_inst_s;
    id_if.pc_to_ID       = head_pc_s;
  end

  // Pointer, count and in-flight tracking; reset outranks branch
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_W{1'b0}};
    end else if (branch) begin
      count_r    <= {CNT_W{1'b0}};
      rd_ptr_r   <= wr_ptr_r;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en;
      if (rd_en) begin
        inflight_pc_r <= pc;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry write; data needs no reset since it is only read while valid
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_pc_r[wr_ptr_r]   <= inflight_pc_r;
      mem_inst_r[wr_ptr_r] <= inst_from_ROM;
    end
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch stage between the PC register and decode. Each cycle it issues the current `pc` to the instruction ROM and captures the returned word one cycle later. It buffers each `{pc, instruction}` pair in a small FIFO and delivers the pairs to decode over a valid/ready handshake. It drives `stall` back to the PC register when buffer credit is exhausted, and on `branch` it flushes all queued and in-flight fetches.

## Interface
- `DEPTH`, 4: queue entries; must be a power of two, minimum 2.
- `ADDR_W`, 32: address and instruction width.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  fetch enable; same signal that enables the PC register.
- `pc`  in  ADDR_W  current fetch address from the PC register.
- `branch`  in  1  redirect; flushes the queue and drops any in-flight fetch this cycle.
- `stall`  out  1  credit exhausted; the PC register must hold `pc`.
- `rd_en`  out  1  ROM read strobe.
- `addr_to_ROM`  out  ADDR_W  ROM read address; equals `pc`.
- `inst_from_ROM`  in  ADDR_W  ROM data; valid exactly 1 cycle after `rd_en`.
- `id_valid`  out  1  queue head is valid.
- `id_ready`  in  1  decode accepts the head.
- `inst_to_decode`  out  ADDR_W  instruction at the head.
- `pc_to_ID`  out  ADDR_W  PC of the head instruction.

## Operation
- **State:** storage `mem[DEPTH]` of `{pc, inst}`; `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap naturally); `count` (0..DEPTH); `inflight` (1 bit); `inflight_pc`.
- **Issue:** `rd_en = start & ~stall & ~branch & ~reset`. `addr_to_ROM = pc`, combinational.
- **In-flight tracking:** on issue, `inflight <= 1` and `inflight_pc <= pc`; otherwise `inflight <= 0`.
- **Credit:** `stall = (count + inflight >= DEPTH)`. It uses registered state only, so a pop in the same cycle does not release credit until the next cycle.
- **Capture:** when `inflight` is 1 and `branch` is 0, write `{inflight_pc, inst_from_ROM}` at `wr_ptr` and increment `wr_ptr`.
- **Pop:** `id_valid = (count != 0)`. A handshake (`id_valid & id_ready`) increments `rd_ptr`. Head outputs are a combinational read at `rd_ptr`.
- **Count update:**
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - credit guarantees no push when `count == DEPTH`.
- **Flush (`branch` = 1):**
  - `count <= 0`, `rd_ptr <= wr_ptr`, `inflight <= 0`.
  - The ROM response arriving that cycle is discarded.
  - A handshake in the same cycle is treated as accepted by decode, but it has no effect on state.
  - No issue that cycle. Fetch resumes the next cycle at the branch target, which the PC register loads.
- **`start` low:** no issue. A pending response is still captured, and the queue still drains.
- **Reset:**
  - `count`, `rd_ptr`, `wr_ptr`, `inflight`, `inflight_pc` = 0.
  - `id_valid` = 0, `rd_en` = 0, `stall` = 0.
  - `inst_to_decode` and `pc_to_ID` are don't-care while `id_valid` = 0.
  - Reset mid-operation discards everything and takes priority over `branch`.

## Timing
- Issue at cycle N; ROM data at N+1; written at the end of N+1.
- Without bypass, `id_valid` first rises at N+2.
- Steady-state throughput is 1 instruction/cycle with `id_ready` held high.
- `stall` rises in the same cycle that `count + inflight` reaches DEPTH. It falls the cycle after a pop reduces that sum.
- `branch` at cycle B: `id_valid` = 0 from B+1. The first target fetch issues at B+1, and its instruction is valid at B+3 (B+2 with bypass).

## Configuration
- **`IF_BYPASS_EN` defined:** when `count == 0` and a non-flushed response arrives, drive `id_valid`, `inst_to_decode` and `pc_to_ID` directly from the response that same cycle.
  - If `id_ready` = 1, the entry is consumed and not written.
  - Otherwise it is written normally.
  - First-instruction latency drops to N+1.
- **Undefined:** every response passes through the queue, giving N+2 latency.

## Test plan
- **Reset, then start:** deassert `reset`, hold `start` = 1 and `id_ready` = 1, with `pc` stepping 0, 4, 8 and ROM returning `0x1000 + pc`.
  - Required: decode sees (0, 0x1000), (4, 0x1004), (8, 0x1008) on consecutive cycles.
  - First valid at issue+2 (issue+1 with `IF_BYPASS_EN`).
- **Backpressure:** `id_ready` = 0, continuous issue with DEPTH=4.
  - Required: `stall` rises once `count + inflight` = 4. No more than 4 entries are held, and none are lost.
  - On `id_ready` = 1, entries drain in order with PCs 0, 4, 8, 12.
- **Branch with full queue and response in flight:** assert `branch` for 1 cycle, then present target `pc` = 0x40.
  - Required: `id_valid` = 0 the next cycle; the dropped response never appears.
  - First delivered pair has `pc_to_ID` = 0x40.
- **Simultaneous push and pop at `count` = 2:** required that `count` stays 2 and FIFO order is preserved.
- **Pointer wrap:** 10 consecutive pushes and pops with DEPTH=4. Required: all 10 delivered in order with correct PC/instruction pairing.
- **Reset mid-stream:** assert `reset` with 3 entries queued and a response in flight.
  - Required: next cycle `id_valid` = 0, `stall` = 0, `rd_en` = 0; stale data never appears.
